// File: rtl/pll_lock_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
// State encoding is visible on the state output port.
package pll_lock_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam int LOSS_W = 8;

  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_seq_sync_ff.sv
// Multi-flop synchronizer for an asynchronous level input.
// All stages clear on reset so the output starts low.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[STAGES-2:0], d};
    end
  end

  assign q = r_q[STAGES-1];

endmodule

// File: rtl/pll_lock_seq.sv
// Power-up and lock supervision sequencer for an iCE40 PLL.
// Holds RESETB, qualifies LOCK, retries and reports lock loss.
module pll_lock_seq
  import pll_lock_seq_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 12000,
  parameter int STABLE_CYCLES = 1200,
  parameter int MAX_RETRY     = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pll_lock,
  input  logic                                restart,
  output logic                                pll_resetb,
  output logic                                ready,
  output logic                                fail,
  output logic [2:0]                          state,
  output logic [clog2_min1(MAX_RETRY+1)-1:0]  retry_cnt,
  output logic [LOSS_W-1:0]                   loss_cnt
);

  localparam int RTY_W = clog2_min1(MAX_RETRY + 1);
  localparam int CYC_W = clog2_min1(
    max3(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

  localparam logic [CYC_W-1:0] HOLD_END =
    CYC_W'(HOLD_CYCLES - 1);
  localparam logic [CYC_W-1:0] TMO_END =
    CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] STB_END =
    CYC_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX =
    RTY_W'(MAX_RETRY);

  logic              w_lock_s;
  state_e            w_nxt;
  logic              w_enter;
  logic              w_rty_inc;
  logic              w_loss_inc;

  state_e            r_state;
  logic [CYC_W-1:0]  r_cyc;
  logic [RTY_W-1:0]  r_retry;
  logic [LOSS_W-1:0] r_loss;
  logic              r_resetb;
  logic              r_ready;
  logic              r_fail;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (w_lock_s)
  );

  // Restart overrides; a lock fall beats STABLE completion,
  // and lock arrival beats the WAIT_LOCK timeout.
  always_comb begin
    w_nxt      = r_state;
    w_rty_inc  = 1'b0;
    w_loss_inc = 1'b0;
    if (restart) begin
      w_nxt = ST_HOLD;
    end else begin
      unique case (r_state)
        ST_HOLD: begin
          if (r_cyc == HOLD_END) w_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_nxt = ST_STABLE;
          end else if (r_cyc == TMO_END) begin
            if (r_retry == RTY_MAX) begin
              w_nxt = ST_FAIL;
            end else begin
              w_nxt     = ST_HOLD;
              w_rty_inc = 1'b1;
            end
          end
        end
        ST_STABLE: begin
          if (!w_lock_s) begin
            w_nxt = ST_WAIT_LOCK;
          end else if (r_cyc == STB_END) begin
            w_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            w_nxt      = ST_HOLD;
            w_loss_inc = 1'b1;
          end
        end
        ST_FAIL: begin
          w_nxt = ST_FAIL;
        end
        default: begin
          w_nxt = ST_HOLD;
        end
      endcase
    end
    w_enter = restart || (w_nxt != r_state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_HOLD;
      r_cyc    <= '0;
      r_retry  <= '0;
      r_loss   <= '0;
      r_resetb <= 1'b0;
      r_ready  <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_enter) begin
        r_cyc <= '0;
      end else if (r_cyc != '1) begin
        r_cyc <= r_cyc + 1'b1;
      end
      if (restart) begin
        r_retry <= '0;
      end else if (w_nxt == ST_RUN && r_state != ST_RUN) begin
        r_retry <= '0;
      end else if (w_rty_inc) begin
        r_retry <= r_retry + 1'b1;
      end
      if (w_loss_inc && r_loss != '1) begin
        r_loss <= r_loss + 1'b1;
      end
      r_resetb <= (w_nxt != ST_HOLD) && (w_nxt != ST_FAIL);
      r_ready  <= (w_nxt == ST_RUN);
      r_fail   <= (w_nxt == ST_FAIL);
    end
  end

  assign pll_resetb = r_resetb;
  assign ready      = r_ready;
  assign fail       = r_fail;
  assign state      = r_state;
  assign retry_cnt  = r_retry;
  assign loss_cnt   = r_loss;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with small timing parameters.
// Table rows drive the long sequences; hand code covers corners.
module tb_pll_lock_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_resetb;
  logic       ready;
  logic       fail;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_lock_seq #(
    .HOLD_CYCLES   (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2),
    .SYNC_STAGES   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .ready      (ready),
    .fail       (fail),
    .state      (state),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  typedef struct {
    logic       lock;
    logic       rst;
    int         n;
    logic [2:0] st;
    logic       rb;
    logic       rdy;
    logic       fl;
    logic [1:0] rty;
    logic [7:0] loss;
  } vec_t;

  vec_t v[22];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string tag, logic [2:0] st, logic rb,
                         logic rdy, logic fl, logic [1:0] rty,
                         logic [7:0] loss);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".resetb"}, 32'(pll_resetb), 32'(rb));
    chk({tag, ".ready"}, 32'(ready), 32'(rdy));
    chk({tag, ".fail"}, 32'(fail), 32'(fl));
    chk({tag, ".retry"}, 32'(retry_cnt), 32'(rty));
    chk({tag, ".loss"}, 32'(loss_cnt), 32'(loss));
  endtask

  task automatic run_rows(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      pll_lock = v[i].lock;
      restart  = v[i].rst;
      step(v[i].n);
      chk_out($sformatf("row%0d", i), v[i].st, v[i].rb,
              v[i].rdy, v[i].fl, v[i].rty, v[i].loss);
    end
    restart = 1'b0;
  endtask

  initial begin
    // lock rst n  st rb rdy fl rty loss
    v[0]  = '{0, 0, 3,  0, 0, 0, 0, 0, 0};
    v[1]  = '{0, 0, 1,  1, 1, 0, 0, 0, 0};
    v[2]  = '{0, 0, 6,  1, 1, 0, 0, 0, 0};
    v[3]  = '{1, 0, 2,  1, 1, 0, 0, 0, 0};
    v[4]  = '{1, 0, 1,  2, 1, 0, 0, 0, 0};
    v[5]  = '{1, 0, 7,  2, 1, 0, 0, 0, 0};
    v[6]  = '{1, 0, 1,  3, 1, 1, 0, 0, 0};
    v[7]  = '{0, 0, 4,  1, 1, 0, 0, 0, 0};
    v[8]  = '{0, 0, 19, 1, 1, 0, 0, 0, 0};
    v[9]  = '{0, 0, 1,  0, 0, 0, 0, 1, 0};
    v[10] = '{0, 0, 4,  1, 1, 0, 0, 1, 0};
    v[11] = '{0, 0, 20, 0, 0, 0, 0, 2, 0};
    v[12] = '{0, 0, 4,  1, 1, 0, 0, 2, 0};
    v[13] = '{0, 0, 19, 1, 1, 0, 0, 2, 0};
    v[14] = '{0, 0, 1,  4, 0, 0, 1, 2, 0};
    v[15] = '{0, 0, 10, 4, 0, 0, 1, 2, 0};
    v[16] = '{0, 1, 1,  0, 0, 0, 0, 0, 0};
    v[17] = '{1, 0, 3,  0, 0, 0, 0, 0, 0};
    v[18] = '{1, 0, 1,  1, 1, 0, 0, 0, 0};
    v[19] = '{1, 0, 1,  2, 1, 0, 0, 0, 0};
    v[20] = '{1, 0, 7,  2, 1, 0, 0, 0, 0};
    v[21] = '{1, 0, 1,  3, 1, 1, 0, 0, 0};

    #12;
    chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // power-up with lock arriving 10 cycles after release
    run_rows(0, 6);

    // one-cycle lock drop while running
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(1);
    chk_out("drop2", 3'd3, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    step(1);
    chk_out("drop3", 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);
    step(3);
    chk_out("rehold", 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);
    step(1);
    chk_out("rewait", 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    step(1);
    chk_out("restb", 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);

    // glitch at cyc=5 lands on the STABLE completion cycle
    step(5);
    chk_out("stb5", 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(1);
    chk_out("glitch1", 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    step(1);
    chk_out("glitch2", 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    step(1);
    chk_out("requal", 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    step(7);
    chk_out("requal7", 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    step(1);
    chk_out("rerun", 3'd3, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1);

    // restart coincident with lock_s fall in RUN
    pll_lock = 1'b0;
    step(2);
    chk_out("prerst", 3'd3, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1);
    restart = 1'b1;
    step(1);
    restart  = 1'b0;
    pll_lock = 1'b1;
    chk_out("rstprio", 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);
    step(4);
    chk_out("rwait", 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    step(1);
    chk_out("rstable", 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);

    // async reset while in STABLE
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    #1;
    chk_out("midrst", 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1);
    rst_n = 1'b1;

    // timeouts to FAIL, then restart into RUN
    run_rows(7, 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
